// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - opcode bit indices and divide sequencer states shared across the core
package exe_stage_pkg;

    localparam int OP_W     = 19;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 6;
    localparam int OP_XOR   = 7;
    localparam int OP_MUL   = 12;
    localparam int OP_MULH  = 13;
    localparam int OP_MULHU = 14;
    localparam int OP_DIV   = 15;
    localparam int OP_DIVU  = 16;
    localparam int OP_MOD   = 17;
    localparam int OP_MODU  = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } div_state_t;

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return op[OP_DIV] | op[OP_DIVU] | op[OP_MOD] | op[OP_MODU];
    endfunction

    function automatic logic op_is_mul(input logic [OP_W-1:0] op);
        return op[OP_MUL] | op[OP_MULH] | op[OP_MULHU];
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID to EX instruction handshake bundle
interface exe_stage_if
    import exe_stage_pkg::*;
#(
    parameter int PC_W = 32
) ();
    logic            ds_to_es_valid;
    logic            es_allowin;
    logic [OP_W-1:0] ds_alu_op;
    logic [31:0]     ds_src1;
    logic [31:0]     ds_src2;
    logic [4:0]      ds_rd;
    logic            ds_rf_we;
    logic [PC_W-1:0] ds_pc;

    modport master (
        output ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_rd, ds_rf_we, ds_pc,
        input  es_allowin
    );

    modport slave (
        input  ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_rd, ds_rf_we, ds_pc,
        output es_allowin
    );
endinterface

// File: rtl/exe_long_op_ctrl.sv
// rtl/exe_long_op_ctrl.sv - divide request/response sequencer, multiply latency counter, ready_go
module exe_long_op_ctrl
    import exe_stage_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        latch,
    input  logic        ds_is_div,
    input  logic        ds_is_mul,
    input  logic        is_div,
    input  logic        is_mul,
    input  logic        ms_allowin,
    output logic        div_req,
    input  logic        div_req_ready,
    input  logic        div_resp_valid,
    input  logic [31:0] div_resp_data,
    output logic [31:0] div_result,
    output logic        es_ready_go,
    output logic        in_drain
);
    div_state_t state;
    logic [2:0] mul_cnt;

    assign es_ready_go = is_div ? (state == S_DONE) :
                         is_mul ? (mul_cnt == 3'd0) : 1'b1;
    assign in_drain    = (state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            div_req    <= 1'b0;
            mul_cnt    <= 3'd0;
            div_result <= 32'd0;
        end else begin
            if (flush)
                mul_cnt <= 3'd0;
            else if (latch)
                mul_cnt <= ds_is_mul ? 3'(MUL_LAT - 1) : 3'd0;
            else if (mul_cnt != 3'd0)
                mul_cnt <= mul_cnt - 3'd1;

            case (state)
                S_IDLE: begin
                    if (latch && ds_is_div) begin
                        state   <= S_REQ;
                        div_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        // an accepted request still owes us a response pulse
                        state   <= div_req_ready ? S_DRAIN : S_IDLE;
                        div_req <= 1'b0;
                    end else if (div_req_ready) begin
                        state   <= S_WAIT;
                        div_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // a response arriving in the flush cycle is already consumed
                    if (flush)
                        state <= div_resp_valid ? S_IDLE : S_DRAIN;
                    else if (div_resp_valid) begin
                        div_result <= div_resp_data;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush)
                        state <= S_IDLE;
                    else if (ms_allowin) begin
                        state   <= (latch && ds_is_div) ? S_REQ : S_IDLE;
                        div_req <= latch && ds_is_div;
                    end
                end
                S_DRAIN: begin
                    if (div_resp_valid)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    resp_only_when_expected: assert property (@(posedge clk) disable iff (reset)
        div_resp_valid |-> (state == S_WAIT || state == S_DRAIN));

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ID/MEM handshake, payload registers and bypass port
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int PC_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    exe_stage_if.slave       ds,
    input  logic             flush,
    output logic [OP_W-1:0]  alu_op,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    input  logic [31:0]      alu_result,
    output logic             div_req,
    input  logic             div_req_ready,
    input  logic             div_resp_valid,
    input  logic [31:0]      div_resp_data,
    output logic             es_to_ms_valid,
    input  logic             ms_allowin,
    output logic [31:0]      es_result,
    output logic [4:0]       es_rd,
    output logic             es_rf_we,
    output logic [PC_W-1:0]  es_pc,
    output logic             es_fwd_we,
    output logic [4:0]       es_fwd_rd,
    output logic [31:0]      es_fwd_data,
    output logic             es_fwd_stall
);
    logic        es_valid;
    logic        es_ready_go;
    logic        in_drain;
    logic        allowin;
    logic        latch;
    logic        is_div;
    logic        is_mul;
    logic        ds_is_div;
    logic        ds_is_mul;
    logic [31:0] div_result;

    assign is_div    = op_is_div(alu_op);
    assign is_mul    = op_is_mul(alu_op);
    assign ds_is_div = op_is_div(ds.ds_alu_op);
    assign ds_is_mul = op_is_mul(ds.ds_alu_op);

    // no new instruction may enter while an orphaned divide response is outstanding
    assign allowin       = (~es_valid | (es_ready_go & ms_allowin)) & ~in_drain;
    assign latch         = ds.ds_to_es_valid & allowin & ~flush;
    assign ds.es_allowin = allowin;

    assign es_to_ms_valid = es_valid & es_ready_go;
    assign es_result      = is_div ? div_result : alu_result;
    assign es_fwd_we      = es_valid & es_rf_we & (es_rd != 5'd0);
    assign es_fwd_rd      = es_rd;
    assign es_fwd_data    = es_result;
    assign es_fwd_stall   = es_fwd_we & ~es_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
            alu_op   <= '0;
            alu_src1 <= 32'd0;
            alu_src2 <= 32'd0;
            es_rd    <= 5'd0;
            es_rf_we <= 1'b0;
            es_pc    <= '0;
        end else begin
            if (flush)
                es_valid <= 1'b0;
            else if (allowin)
                es_valid <= ds.ds_to_es_valid;

            if (latch) begin
                alu_op   <= ds.ds_alu_op;
                alu_src1 <= ds.ds_src1;
                alu_src2 <= ds.ds_src2;
                es_rd    <= ds.ds_rd;
                es_rf_we <= ds.ds_rf_we;
                es_pc    <= ds.ds_pc;
            end
        end
    end

    exe_long_op_ctrl #(
        .MUL_LAT(MUL_LAT)
    ) u_long_op (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .latch          (latch),
        .ds_is_div      (ds_is_div),
        .ds_is_mul      (ds_is_mul),
        .is_div         (is_div),
        .is_mul         (is_mul),
        .ms_allowin     (ms_allowin),
        .div_req        (div_req),
        .div_req_ready  (div_req_ready),
        .div_resp_valid (div_resp_valid),
        .div_resp_data  (div_resp_data),
        .div_result     (div_result),
        .es_ready_go    (es_ready_go),
        .in_drain       (in_drain)
    );

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed vector bench for exe_stage
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic            clk;
    logic            reset;
    logic            flush;
    logic [OP_W-1:0] alu_op;
    logic [31:0]     alu_src1;
    logic [31:0]     alu_src2;
    logic [31:0]     alu_result;
    logic            div_req;
    logic            div_req_ready;
    logic            div_resp_valid;
    logic [31:0]     div_resp_data;
    logic            es_to_ms_valid;
    logic            ms_allowin;
    logic [31:0]     es_result;
    logic [4:0]      es_rd;
    logic            es_rf_we;
    logic [31:0]     es_pc;
    logic            es_fwd_we;
    logic [4:0]      es_fwd_rd;
    logic [31:0]     es_fwd_data;
    logic            es_fwd_stall;

    int n_chk  = 0;
    int n_fail = 0;

    exe_stage_if #(.PC_W(32)) ds_if ();

    exe_stage #(.MUL_LAT(2), .PC_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ds             (ds_if),
        .flush          (flush),
        .alu_op         (alu_op),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .alu_result     (alu_result),
        .div_req        (div_req),
        .div_req_ready  (div_req_ready),
        .div_resp_valid (div_resp_valid),
        .div_resp_data  (div_resp_data),
        .es_to_ms_valid (es_to_ms_valid),
        .ms_allowin     (ms_allowin),
        .es_result      (es_result),
        .es_rd          (es_rd),
        .es_rf_we       (es_rf_we),
        .es_pc          (es_pc),
        .es_fwd_we      (es_fwd_we),
        .es_fwd_rd      (es_fwd_rd),
        .es_fwd_data    (es_fwd_data),
        .es_fwd_stall   (es_fwd_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in driven from the latched operand bus
    always_comb begin
        alu_result = 32'd0;
        if (alu_op[OP_ADD])      alu_result = alu_src1 + alu_src2;
        else if (alu_op[OP_SUB]) alu_result = alu_src1 - alu_src2;
        else if (alu_op[OP_AND]) alu_result = alu_src1 & alu_src2;
        else if (alu_op[OP_OR])  alu_result = alu_src1 | alu_src2;
        else if (alu_op[OP_XOR]) alu_result = alu_src1 ^ alu_src2;
        else if (alu_op[OP_MUL]) alu_result = alu_src1 * alu_src2;
    end

    typedef struct {
        logic [OP_W-1:0] op;
        logic [31:0]     s1;
        logic [31:0]     s2;
        logic [4:0]      rd;
        logic            we;
        logic [31:0]     pc;
        logic [31:0]     exp_res;
        logic            exp_fwd_we;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [OP_W-1:0] onehot(input int b);
        logic [OP_W-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ds_drive(input logic v, input logic [OP_W-1:0] op, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [4:0] rd, input logic we,
                            input logic [31:0] pc);
        ds_if.ds_to_es_valid = v;
        ds_if.ds_alu_op      = op;
        ds_if.ds_src1        = s1;
        ds_if.ds_src2        = s2;
        ds_if.ds_rd          = rd;
        ds_if.ds_rf_we       = we;
        ds_if.ds_pc          = pc;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".valid"},   es_to_ms_valid,    0);
        chk({tag, ".allowin"}, ds_if.es_allowin,  1);
        chk({tag, ".div_req"}, div_req,           0);
        chk({tag, ".result"},  es_result,         0);
        chk({tag, ".alu_op"},  32'(alu_op),       0);
        chk({tag, ".src1"},    alu_src1,          0);
        chk({tag, ".src2"},    alu_src2,          0);
        chk({tag, ".rd"},      es_rd,             0);
        chk({tag, ".rf_we"},   es_rf_we,          0);
        chk({tag, ".pc"},      es_pc,             0);
        chk({tag, ".fwd_we"},  es_fwd_we,         0);
        chk({tag, ".stall"},   es_fwd_stall,      0);
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        ms_allowin     = 1'b1;
        div_req_ready  = 1'b0;
        div_resp_valid = 1'b0;
        div_resp_data  = 32'd0;
        ds_drive(0, '0, 0, 0, 0, 0, 0);

        vecs[0] = '{op: onehot(OP_ADD), s1: 32'd5,          s2: 32'd7,          rd: 5'd5,  we: 1'b1, pc: 32'h1000, exp_res: 32'd12,         exp_fwd_we: 1'b1};
        vecs[1] = '{op: onehot(OP_ADD), s1: 32'hFFFF_FFFF,  s2: 32'd1,          rd: 5'd6,  we: 1'b1, pc: 32'h1004, exp_res: 32'd0,          exp_fwd_we: 1'b1};
        vecs[2] = '{op: onehot(OP_SUB), s1: 32'd3,          s2: 32'd5,          rd: 5'd7,  we: 1'b1, pc: 32'h1008, exp_res: 32'hFFFF_FFFE,  exp_fwd_we: 1'b1};
        vecs[3] = '{op: onehot(OP_AND), s1: 32'hF0F0_F0F0,  s2: 32'h0FF0_0FF0,  rd: 5'd0,  we: 1'b1, pc: 32'h100C, exp_res: 32'h00F0_00F0,  exp_fwd_we: 1'b0};
        vecs[4] = '{op: onehot(OP_OR),  s1: 32'h1234_0000,  s2: 32'h0000_5678,  rd: 5'd9,  we: 1'b0, pc: 32'h1010, exp_res: 32'h1234_5678,  exp_fwd_we: 1'b0};
        vecs[5] = '{op: onehot(OP_XOR), s1: 32'hAAAA_AAAA,  s2: 32'hFFFF_FFFF,  rd: 5'd31, we: 1'b1, pc: 32'h1014, exp_res: 32'h5555_5555,  exp_fwd_we: 1'b1};

        repeat (2) cyc();
        check_quiet("reset");
        reset = 1'b0;

        // single-cycle ops streamed back to back
        for (int i = 0; i < 6; i++) begin
            ds_drive(1, vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].rd, vecs[i].we, vecs[i].pc);
            cyc();
            chk($sformatf("vec%0d.valid", i),   es_to_ms_valid,   1);
            chk($sformatf("vec%0d.result", i),  es_result,        vecs[i].exp_res);
            chk($sformatf("vec%0d.rd", i),      es_rd,            vecs[i].rd);
            chk($sformatf("vec%0d.rf_we", i),   es_rf_we,         vecs[i].we);
            chk($sformatf("vec%0d.pc", i),      es_pc,            vecs[i].pc);
            chk($sformatf("vec%0d.fwd_we", i),  es_fwd_we,        vecs[i].exp_fwd_we);
            chk($sformatf("vec%0d.fwd_rd", i),  es_fwd_rd,        vecs[i].rd);
            chk($sformatf("vec%0d.fwd_dat", i), es_fwd_data,      vecs[i].exp_res);
            chk($sformatf("vec%0d.stall", i),   es_fwd_stall,     0);
            chk($sformatf("vec%0d.allowin", i), ds_if.es_allowin, 1);
        end
        ds_if.ds_to_es_valid = 1'b0;
        cyc();
        chk("vec.drained", es_to_ms_valid, 0);

        // multiply, two-cycle latency
        ds_drive(1, onehot(OP_MUL), 32'hFFFF_FFFF, 32'd3, 5'd3, 1'b1, 32'h2000);
        cyc();
        ds_if.ds_to_es_valid = 1'b0;
        chk("mul.c1.valid",   es_to_ms_valid,   0);
        chk("mul.c1.stall",   es_fwd_stall,     1);
        chk("mul.c1.allowin", ds_if.es_allowin, 0);
        cyc();
        chk("mul.c2.valid",   es_to_ms_valid,   1);
        chk("mul.c2.result",  es_result,        32'hFFFF_FFFD);
        chk("mul.c2.stall",   es_fwd_stall,     0);
        cyc();
        chk("mul.gone",       es_to_ms_valid,   0);

        // divide with a slow request accept and a late response
        ds_drive(1, onehot(OP_DIV), 32'd100, 32'd7, 5'd4, 1'b1, 32'h3000);
        cyc();
        ds_if.ds_to_es_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("div.req_held",    div_req,          1);
            chk("div.req_allowin", ds_if.es_allowin, 0);
            chk("div.req_valid",   es_to_ms_valid,   0);
            chk("div.req_stall",   es_fwd_stall,     1);
            cyc();
        end
        div_req_ready = 1'b1;
        chk("div.req_accept", div_req, 1);
        cyc();
        div_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("div.wait_req",     div_req,          0);
            chk("div.wait_allowin", ds_if.es_allowin, 0);
            chk("div.wait_valid",   es_to_ms_valid,   0);
            chk("div.wait_result",  es_result,        0);
            cyc();
        end
        div_resp_valid = 1'b1;
        div_resp_data  = 32'd14;
        chk("div.pulse_valid", es_to_ms_valid, 0);
        cyc();
        div_resp_valid = 1'b0;
        div_resp_data  = 32'd0;
        chk("div.done_valid",   es_to_ms_valid,   1);
        chk("div.done_result",  es_result,        32'd14);
        chk("div.done_fwd",     es_fwd_data,      32'd14);
        chk("div.done_stall",   es_fwd_stall,     0);
        chk("div.done_allowin", ds_if.es_allowin, 1);
        cyc();
        chk("div.gone", es_to_ms_valid, 0);

        // divide completes into a stalled MEM, then a back-to-back divide
        ms_allowin = 1'b0;
        ds_drive(1, onehot(OP_DIV), 32'd100, 32'd7, 5'd5, 1'b1, 32'h3100);
        cyc();
        ds_if.ds_to_es_valid = 1'b0;
        div_req_ready = 1'b1;
        cyc();
        div_req_ready  = 1'b0;
        div_resp_valid = 1'b1;
        div_resp_data  = 32'd14;
        cyc();
        div_resp_valid = 1'b0;
        div_resp_data  = 32'd0;
        ds_drive(1, onehot(OP_DIV), 32'd81, 32'd9, 5'd10, 1'b1, 32'h3300);
        for (int k = 0; k < 4; k++) begin
            chk("stall.valid",   es_to_ms_valid,   1);
            chk("stall.result",  es_result,        32'd14);
            chk("stall.pc",      es_pc,            32'h3100);
            chk("stall.allowin", ds_if.es_allowin, 0);
            cyc();
        end
        ms_allowin = 1'b1;
        #1;
        chk("stall.release", ds_if.es_allowin, 1);
        cyc();
        ds_if.ds_to_es_valid = 1'b0;
        chk("b2b.div_req", div_req,        1);
        chk("b2b.pc",      es_pc,          32'h3300);
        chk("b2b.valid",   es_to_ms_valid, 0);

        // flush while the request is still waiting for ready; ID's offer is ignored
        flush = 1'b1;
        ds_drive(1, onehot(OP_ADD), 32'd1, 32'd1, 5'd11, 1'b1, 32'h3400);
        cyc();
        flush = 1'b0;
        ds_if.ds_to_es_valid = 1'b0;
        chk("flreq.div_req", div_req,          0);
        chk("flreq.valid",   es_to_ms_valid,   0);
        chk("flreq.allowin", ds_if.es_allowin, 1);
        chk("flreq.fwd_we",  es_fwd_we,        0);

        // flush in WAIT: drain the orphaned response before accepting more work
        ds_drive(1, onehot(OP_DIV), 32'd9, 32'd2, 5'd6, 1'b1, 32'h4000);
        cyc();
        ds_if.ds_to_es_valid = 1'b0;
        div_req_ready = 1'b1;
        cyc();
        div_req_ready = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        ds_drive(1, onehot(OP_ADD), 32'd1, 32'd2, 5'd7, 1'b1, 32'h4100);
        for (int k = 0; k < 2; k++) begin
            chk("drain.valid",   es_to_ms_valid,   0);
            chk("drain.allowin", ds_if.es_allowin, 0);
            chk("drain.fwd_we",  es_fwd_we,        0);
            cyc();
        end
        div_resp_valid = 1'b1;
        div_resp_data  = 32'h0000_DEAD;
        chk("drain.pulse_allowin", ds_if.es_allowin, 0);
        cyc();
        div_resp_valid = 1'b0;
        div_resp_data  = 32'd0;
        chk("drain.idle_allowin", ds_if.es_allowin, 1);
        chk("drain.idle_valid",   es_to_ms_valid,   0);
        cyc();
        ds_if.ds_to_es_valid = 1'b0;
        chk("drain.add_valid",  es_to_ms_valid, 1);
        chk("drain.add_result", es_result,      32'd3);
        chk("drain.add_pc",     es_pc,          32'h4100);
        cyc();

        // reset while a divide request is outstanding
        ds_drive(1, onehot(OP_DIV), 32'd50, 32'd5, 5'd9, 1'b1, 32'h5000);
        cyc();
        ds_if.ds_to_es_valid = 1'b0;
        chk("midrst.div_req_before", div_req, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_quiet("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
